// File: rtl/multi_channel_watchdog_if.sv
// Control and status bundle between software-facing logic and the watchdog.
interface multi_channel_watchdog_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] enable;
    logic [N_CH-1:0] heartbeat;
    logic            force_reset;
    logic [N_CH-1:0] clear_trip;
    logic [N_CH-1:0] warning;
    logic [N_CH-1:0] triggered;
    logic            any_triggered;
    logic            sys_reset_req;

    modport master (
        output enable, heartbeat, force_reset, clear_trip,
        input  warning, triggered, any_triggered, sys_reset_req
    );

    modport slave (
        input  enable, heartbeat, force_reset, clear_trip,
        output warning, triggered, any_triggered, sys_reset_req
    );
endinterface

// File: rtl/multi_channel_watchdog.sv
// N-channel watchdog with per-channel warning/trip and a shared reset request.
// Define WDT_WINDOW_EN to trip on kicks arriving earlier than WIN_MIN_CYCLES.
module multi_channel_watchdog #(
    parameter int N_CH           = 4,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int WARN_CYCLES    = 37_500_000,
    parameter int WIN_MIN_CYCLES = 1_000
) (
    input logic                   clk,
    input logic                   rst,
    multi_channel_watchdog_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, WARN, TRIP} state_t;

    localparam logic [CNT_W-1:0] WARN_LAST = CNT_W'(WARN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    if (N_CH < 1 || N_CH > 16 || WARN_CYCLES <= 0 ||
        WARN_CYCLES >= TIMEOUT_CYCLES ||
        WIN_MIN_CYCLES >= WARN_CYCLES) begin : g_bad_cfg
        $error("multi_channel_watchdog: illegal parameters");
    end

    logic [N_CH-1:0] hb_q;
    logic [N_CH-1:0] hb_edge;
    logic [N_CH-1:0] go_trip;
    logic [N_CH-1:0] warn_v;
    logic [N_CH-1:0] trip_v;
    logic            req_q;

    assign hb_edge = bus.heartbeat & ~hb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_q  <= '0;
            req_q <= 1'b0;
        end else begin
            hb_q  <= bus.heartbeat;
            req_q <= |go_trip;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             warn_q;
        logic             trip_q;
        logic             en;
        logic             hb;
        logic             forced;
        logic             live;
        logic             leave_trip;
        logic             early;

        assign en         = bus.enable[i];
        assign hb         = hb_edge[i];
        assign forced     = bus.force_reset & en;
        assign live       = ((state == RUN) || (state == WARN)) & en;
        assign leave_trip = (state == TRIP) & bus.clear_trip[i] & ~forced;

`ifdef WDT_WINDOW_EN
        localparam logic [CNT_W-1:0] WIN_MIN = CNT_W'(WIN_MIN_CYCLES);
        logic exempt;

        // First kick after (re)starting may land at any time.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                exempt <= 1'b0;
            else if (((state == IDLE) & en) | leave_trip)
                exempt <= 1'b1;
            else if (hb)
                exempt <= 1'b0;
        end

        assign early = (state == RUN) & hb & ~exempt & (cnt < WIN_MIN);
`else
        assign early = 1'b0;
`endif

        // A kick landing on the timeout cycle reloads instead of tripping.
        assign go_trip[i] = (state != TRIP) &
                            (forced | (live & (early | (~hb & (cnt == TO_LAST)))));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= IDLE;
                cnt    <= '0;
                warn_q <= 1'b0;
                trip_q <= 1'b0;
            end else if (go_trip[i]) begin
                state  <= TRIP;
                warn_q <= 1'b0;
                trip_q <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (en) state <= RUN;
                    end
                    RUN, WARN: begin
                        if (!en) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            warn_q <= 1'b0;
                        end else if (hb) begin
                            state  <= RUN;
                            cnt    <= '0;
                            warn_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (cnt == WARN_LAST) begin
                                state  <= WARN;
                                warn_q <= 1'b1;
                            end
                        end
                    end
                    TRIP: begin
                        if (leave_trip) begin
                            state  <= en ? RUN : IDLE;
                            cnt    <= '0;
                            trip_q <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign warn_v[i] = warn_q;
        assign trip_v[i] = trip_q;
    end

    assign bus.warning       = warn_v;
    assign bus.triggered     = trip_v;
    assign bus.any_triggered = |trip_v;
    assign bus.sys_reset_req = req_q;
endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Scoreboard bench: stimulus queues expected outputs per cycle, a monitor checks them.
`timescale 1ns/1ps
module tb_multi_channel_watchdog;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_channel_watchdog_if #(.N_CH(N)) bus ();

    multi_channel_watchdog #(
        .N_CH(N),
        .CNT_W(32),
        .TIMEOUT_CYCLES(16),
        .WARN_CYCLES(12),
        .WIN_MIN_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int         at;
        logic [3:0] warn;
        logic [3:0] trig;
        logic       req;
        string      name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int exp_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples 2 ns after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (bus.sys_reset_req === 1'b1) pulses++;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.at < cyc) begin
                errors++;
                $display("FAIL %s: cycle %0d passed unchecked (now %0d)",
                         e.name, e.at, cyc);
            end else if (bus.warning !== e.warn || bus.triggered !== e.trig ||
                         bus.any_triggered !== (|e.trig) ||
                         bus.sys_reset_req !== e.req) begin
                errors++;
                $display("FAIL %s @%0d: got warn=%b trig=%b any=%b req=%b, want warn=%b trig=%b any=%b req=%b",
                         e.name, cyc, bus.warning, bus.triggered,
                         bus.any_triggered, bus.sys_reset_req,
                         e.warn, e.trig, |e.trig, e.req);
            end
        end
    end

    task automatic expect_at(input int at, input logic [3:0] w,
                             input logic [3:0] t, input logic r,
                             input string nm);
        exp_t e;
        e.at   = at;
        e.warn = w;
        e.trig = t;
        e.req  = r;
        e.name = nm;
        sb.push_back(e);
        if (r) exp_pulses++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_now(input string nm, input logic [9:0] got,
                             input logic [9:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, want %b", nm, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        int r;
        bus.enable      = '0;
        bus.heartbeat   = '0;
        bus.force_reset = 1'b0;
        bus.clear_trip  = '0;
        rst = 1'b1;
        tick(3);
        check_now("reset_state", {bus.warning, bus.triggered,
                  bus.any_triggered, bus.sys_reset_req}, 10'd0);
        rst = 1'b0;
        tick(1);

        // Free-running ch0 until warning then trip
        c = cyc;
        bus.enable = 4'b0001;
        expect_at(c + 12, 4'b0000, 4'b0000, 1'b0, "t1_pre_warn");
        expect_at(c + 13, 4'b0001, 4'b0000, 1'b0, "t1_warn");
        expect_at(c + 16, 4'b0001, 4'b0000, 1'b0, "t1_pre_trip");
        expect_at(c + 17, 4'b0000, 4'b0001, 1'b1, "t1_trip");
        expect_at(c + 18, 4'b0000, 4'b0001, 1'b0, "t1_trip_hold");
        tick(20);

        c = cyc;
        bus.clear_trip = 4'b0001;
        expect_at(c + 1,  4'b0000, 4'b0000, 1'b0, "t1_clear");
        expect_at(c + 12, 4'b0000, 4'b0000, 1'b0, "t1_restart_pre_warn");
        expect_at(c + 13, 4'b0001, 4'b0000, 1'b0, "t1_restart_warn");
        tick(1);
        bus.clear_trip = '0;
        tick(13);

        c = cyc;
        bus.enable = '0;
        expect_at(c + 1, 4'b0000, 4'b0000, 1'b0, "t1_disable");
        tick(2);

        // Regular kicks every 10 cycles
        bus.enable = 4'b0001;
        for (int k = 0; k < 100; k++) begin
            bus.heartbeat[0] = (k % 10 == 5);
            expect_at(cyc + 1, 4'b0000, 4'b0000, 1'b0, "t2_kick");
            tick(1);
        end
        bus.heartbeat = '0;
        bus.enable    = '0;
        tick(2);

        // Kick on the timeout cycle reloads
        c = cyc;
        bus.enable = 4'b0001;
        expect_at(c + 16, 4'b0001, 4'b0000, 1'b0, "t3_warn_before_kick");
        expect_at(c + 17, 4'b0000, 4'b0000, 1'b0, "t3_kick_at_timeout");
        expect_at(c + 28, 4'b0000, 4'b0000, 1'b0, "t3_reloaded_pre_warn");
        expect_at(c + 29, 4'b0001, 4'b0000, 1'b0, "t3_reloaded_warn");
        expect_at(c + 32, 4'b0001, 4'b0000, 1'b0, "t3_pre_trip");
        expect_at(c + 33, 4'b0000, 4'b0001, 1'b1, "t3_trip");
        tick(16);
        bus.heartbeat[0] = 1'b1;
        tick(1);
        bus.heartbeat = '0;
        tick(17);

        c = cyc;
        bus.enable     = '0;
        bus.clear_trip = 4'b0001;
        expect_at(c + 1,  4'b0000, 4'b0000, 1'b0, "t3_clear_disabled");
        expect_at(c + 14, 4'b0000, 4'b0000, 1'b0, "t3_idle_no_warn");
        tick(1);
        bus.clear_trip = '0;
        tick(14);

        // Forced trip of enabled channels, then clear
        c = cyc;
        bus.enable      = 4'b0101;
        bus.force_reset = 1'b1;
        expect_at(c + 1, 4'b0000, 4'b0101, 1'b1, "t4_force");
        expect_at(c + 2, 4'b0000, 4'b0101, 1'b0, "t4_single_pulse");
        expect_at(c + 3, 4'b0000, 4'b0101, 1'b0, "t4_force_again_no_pulse");
        expect_at(c + 4, 4'b0000, 4'b0000, 1'b0, "t4_clear_both");
        expect_at(c + 15, 4'b0000, 4'b0000, 1'b0, "t5_pre_warn");
        expect_at(c + 16, 4'b0101, 4'b0000, 1'b0, "t5_warn");
        tick(1);
        bus.force_reset = 1'b0;
        tick(1);
        bus.force_reset = 1'b1;
        bus.clear_trip  = 4'b0001;
        tick(1);
        bus.force_reset = 1'b0;
        bus.clear_trip  = 4'b0101;
        tick(1);
        bus.clear_trip = '0;
        tick(13);

        // Async reset in the middle of WARN
        rst = 1'b1;
        #1;
        check_now("t5_rst_immediate", {bus.warning, bus.triggered,
                  bus.any_triggered, bus.sys_reset_req}, 10'd0);
        tick(2);
        rst = 1'b0;
        r = cyc;
        expect_at(r + 12, 4'b0000, 4'b0000, 1'b0, "t5_restart_pre_warn");
        expect_at(r + 13, 4'b0101, 4'b0000, 1'b0, "t5_restart_warn");
        tick(14);
        bus.enable = '0;
        tick(2);

        // Kicks two cycles apart after the first kick
        c = cyc;
        bus.enable = 4'b0001;
        expect_at(c + 3, 4'b0000, 4'b0000, 1'b0, "t6_first_kick");
`ifdef WDT_WINDOW_EN
        expect_at(c + 5, 4'b0000, 4'b0001, 1'b1, "t6_early_kick_trip");
        expect_at(c + 6, 4'b0000, 4'b0001, 1'b0, "t6_early_kick_hold");
`else
        expect_at(c + 5, 4'b0000, 4'b0000, 1'b0, "t6_early_kick_reload");
        expect_at(c + 6, 4'b0000, 4'b0000, 1'b0, "t6_early_kick_hold");
`endif
        tick(2);
        bus.heartbeat[0] = 1'b1;
        tick(1);
        bus.heartbeat = '0;
        tick(1);
        bus.heartbeat[0] = 1'b1;
        tick(1);
        bus.heartbeat = '0;
        tick(3);
        bus.enable     = '0;
        bus.clear_trip = 4'b0001;
        tick(1);
        bus.clear_trip = '0;
        tick(3);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        checks++;
        if (pulses != exp_pulses) begin
            errors++;
            $display("FAIL pulse_count: got %0d, want %0d", pulses, exp_pulses);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
